// File: rtl/reward_spawn_controller.sv
// Reward spawn controller: initiator of the set_require/set_finish handshake.
// Rejection-samples a reward type and tile from a 16-bit LFSR, holds it on the map
// until claimed or expired, then waits a cooldown before the next spawn search.
module reward_spawn_controller #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int unsigned X_MAX          = 24,
  parameter int unsigned Y_MAX          = 18,
  parameter int unsigned LIFETIME_TICKS = 40,
  parameter int unsigned COOLDOWN_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_4hz,
  input  logic       enable,
  input  logic       set_finish,
  output logic       set_require,
  output logic [2:0] reward_type,
  output logic [4:0] random_xpos,
  output logic [4:0] random_ypos,
  output logic       dout,
  output logic [7:0] claim_cnt,
  output logic [7:0] expire_cnt
);

  localparam int unsigned LifeW = $clog2(LIFETIME_TICKS) + 1;
  localparam int unsigned CdW   = $clog2(COOLDOWN_TICKS) + 1;
  // Timers are wide enough to hold the full count, so these casts never truncate.
  localparam logic [LifeW-1:0] LifeLast = LifeW'(LIFETIME_TICKS - 1);
  localparam logic [CdW-1:0]   CdLast   = CdW'(COOLDOWN_TICKS - 1);
  localparam logic [4:0]       XMax     = 5'(X_MAX);
  localparam logic [4:0]       YMax     = 5'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StSpawn, StActive, StCooldown} state_e;

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [LifeW-1:0] life_q, life_d;
  logic [CdW-1:0]   cd_q, cd_d;
  logic             req_q, req_d;
  logic [2:0]       type_q, type_d;
  logic [4:0]       x_q, x_d;
  logic [4:0]       y_q, y_d;
  logic [7:0]       claim_q, claim_d;
  logic [7:0]       expire_q, expire_d;

  logic [4:0] cand_x, cand_y;
  logic [2:0] cand_t;
  logic       cand_ok;

  // Candidate decode; a lingering set_finish blocks acceptance so one claim
  // level cannot consume two rewards.
  always_comb begin
    cand_x  = lfsr_q[4:0];
    cand_y  = lfsr_q[9:5];
    cand_t  = lfsr_q[12:10];
    cand_ok = (cand_x != 5'd0) && (cand_x <= XMax) &&
              (cand_y != 5'd0) && (cand_y <= YMax) &&
              (cand_t != 3'd0) && (cand_t <= 3'd4) && !set_finish;
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    life_d   = life_q;
    cd_d     = cd_q;
    req_d    = req_q;
    type_d   = type_q;
    x_d      = x_q;
    y_d      = y_q;
    claim_d  = claim_q;
    expire_d = expire_q;

    if (enable) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    if (!enable) begin
      state_d = StIdle;
      life_d  = '0;
      cd_d    = '0;
      req_d   = 1'b0;
      type_d  = 3'd0;
      x_d     = 5'd0;
      y_d     = 5'd0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StSpawn;
        StSpawn: begin
          if (cand_ok) begin
            req_d   = 1'b1;
            type_d  = cand_t;
            x_d     = cand_x;
            y_d     = cand_y;
            life_d  = '0;
            state_d = StActive;
          end
        end
        StActive: begin
          if (set_finish || (tick_4hz && (life_q == LifeLast))) begin
            // Claim wins over a coincident expiry tick.
            if (set_finish) begin
              if (claim_q != 8'hFF) claim_d = claim_q + 8'd1;
            end else begin
              if (expire_q != 8'hFF) expire_d = expire_q + 8'd1;
            end
            req_d   = 1'b0;
            type_d  = 3'd0;
            x_d     = 5'd0;
            y_d     = 5'd0;
            cd_d    = '0;
            state_d = StCooldown;
          end else if (tick_4hz) begin
            life_d = life_q + 1'b1;
          end
        end
        StCooldown: begin
          if (tick_4hz) begin
            if (cd_q == CdLast) begin
              cd_d    = '0;
              state_d = StSpawn;
            end else begin
              cd_d = cd_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lfsr_q   <= LFSR_SEED;
      life_q   <= '0;
      cd_q     <= '0;
      req_q    <= 1'b0;
      type_q   <= 3'd0;
      x_q      <= 5'd0;
      y_q      <= 5'd0;
      claim_q  <= 8'd0;
      expire_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      life_q   <= life_d;
      cd_q     <= cd_d;
      req_q    <= req_d;
      type_q   <= type_d;
      x_q      <= x_d;
      y_q      <= y_d;
      claim_q  <= claim_d;
      expire_q <= expire_d;
    end
  end

  assign set_require = req_q;
  assign reward_type = type_q;
  assign random_xpos = x_q;
  assign random_ypos = y_q;
  assign dout        = lfsr_q[0];
  assign claim_cnt   = claim_q;
  assign expire_cnt  = expire_q;

endmodule
